// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
//   Shared types and constants for the instruction-memory loader.
//
//   loader_state_t  : loader FSM state encoding
//   BYTES_PER_WORD  : bytes packed into one MIPS instruction word
//   IMEM_ADDR_W     : default word-index width of the instruction memory
// -----------------------------------------------------------------------------
package imem_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int IMEM_ADDR_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

  // Clamp a requested word count to the memory capacity (2**addr_w words).
  function automatic int unsigned clamp_count(input int unsigned req,
                                              input int unsigned addr_w);
    int unsigned cap;
    cap = 32'd1 << addr_w;
    return (req > cap) ? cap : req;
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// -----------------------------------------------------------------------------
// imem_word_packer
//   Packs a byte stream big-endian into 32-bit words. The first byte of a word
//   ends up in word_out[31:24] once four bytes have been shifted in.
//
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset (clears counter and word)
//   clr        in   discard any partial word (byte counter back to 0)
//   load       in   accept byte_in this cycle
//   byte_in    in   [7:0]  incoming byte
//   word_out   out  [31:0] shift register contents (registered)
//   word_full  out  the byte accepted this cycle completes a word
// -----------------------------------------------------------------------------
module imem_word_packer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        word_full
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] shift_q,    shift_d;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    if (clr) begin
      // The shift register is left alone; only the byte position matters
      // for realigning the next word.
      byte_cnt_d = 2'd0;
    end else if (load) begin
      shift_d    = {shift_q[23:0], byte_in};
      byte_cnt_d = byte_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt_q <= 2'd0;
      shift_q    <= 32'd0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
    end
  end

  assign word_out  = shift_q;
  assign word_full = load && !clr && (byte_cnt_q == LAST_BYTE);

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Receives a program as a byte stream, packs it big-endian into 32-bit words
//   and writes them to consecutive word addresses starting at 0. Keeps the CPU
//   in reset until the whole program has been written.
//
//   clk         in   system clock
//   rst_n       in   synchronous active-low reset
//   start       in   begin a load (ignored while busy)
//   word_count  in   [ADDR_W:0] words to load, sampled on accepted start
//   abort       in   cancel a load in progress
//   byte_valid  in   byte_data is valid
//   byte_data   in   [7:0] program byte, first byte = instr[31:24]
//   byte_ready  out  a byte is accepted this cycle
//   wr_en       out  one-cycle memory write strobe
//   wr_addr     out  [31:0] byte address of the word being written
//   wr_data     out  [31:0] packed instruction word
//   busy        out  load in progress
//   done        out  load finished, held until next start or reset
//   cpu_rst_n   out  0 holds the CPU in reset; equals done
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | after reset or abort; waiting for start
//   RECV  | accepting bytes into the packer
//   WRITE | single cycle with wr_en asserted for the packed word
//   DONE  | all words written; CPU released; waiting for a new start
// -----------------------------------------------------------------------------
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              abort,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [31:0]       wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              cpu_rst_n
);

  localparam logic [ADDR_W:0] CAPACITY =
    (ADDR_W+1)'(clamp_count(32'hFFFF_FFFF, ADDR_W));

  loader_state_t     state_q,    state_d;
  logic [ADDR_W:0]   count_q,    count_d;
  logic [ADDR_W:0]   word_idx_q, word_idx_d;
  logic              wr_en_q,    wr_en_d;
  logic [31:0]       wr_addr_q,  wr_addr_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;

  logic              pk_clr;
  logic              pk_load;
  logic              pk_full;
  logic [31:0]       pk_word;
  logic [ADDR_W:0]   idx_inc;
  logic [ADDR_W:0]   count_req;

  imem_word_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (pk_clr),
    .load      (pk_load),
    .byte_in   (byte_data),
    .word_out  (pk_word),
    .word_full (pk_full)
  );

  assign idx_inc   = word_idx_q + (ADDR_W+1)'(1);
  assign count_req = (word_count > CAPACITY) ? CAPACITY : word_count;

  // An abort in the same cycle would discard the byte, so the handshake is
  // withheld rather than silently dropping it.
  assign byte_ready = (state_q == RECV) && !abort;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    pk_clr     = 1'b0;
    pk_load    = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start && !abort) begin
          count_d    = count_req;
          word_idx_d = '0;
          pk_clr     = 1'b1;
          state_d    = (count_req == '0) ? DONE : RECV;
        end
      end

      RECV: begin
        if (abort) begin
          pk_clr  = 1'b1;
          state_d = IDLE;
        end else if (byte_valid) begin
          pk_load = 1'b1;
          if (pk_full) state_d = WRITE;
        end
      end

      WRITE: begin
        if (abort) begin
          pk_clr  = 1'b1;
          state_d = IDLE;
        end else begin
          word_idx_d = idx_inc;
          state_d    = (idx_inc == count_q) ? DONE : RECV;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are derived from the next state so they line up with
  // the state they describe.
  always_comb begin
    wr_en_d   = (state_d == WRITE);
    busy_d    = (state_d == RECV) || (state_d == WRITE);
    done_d    = (state_d == DONE);
    wr_addr_d = wr_addr_q;
    if (state_d == WRITE) begin
      wr_addr_d = {{(30-ADDR_W){1'b0}}, word_idx_q[ADDR_W-1:0], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      word_idx_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = pk_word;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cpu_rst_n = done_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [8:0]  word_count;
  logic        abort;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        cpu_rst_n;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  logic [31:0] last_addr = 32'd0;
  logic [63:0] sb [$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .word_count (word_count),
    .abort      (abort),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .cpu_rst_n  (cpu_rst_n)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the next expected word.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      logic [63:0] e;
      wr_cnt++;
      last_addr = wr_addr;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", wr_addr, wr_data);
      end else begin
        e = sb.pop_front();
        if (wr_addr !== e[63:32] || wr_data !== e[31:0]) begin
          bad++;
          $display("FAIL write: got addr %h data %h expected addr %h data %h",
                   wr_addr, wr_data, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic expect_wr(input logic [31:0] addr, input logic [31:0] data);
    sb.push_back({addr, data});
  endtask

  task automatic do_start(input logic [8:0] wc);
    start = 1'b1;
    word_count = wc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    while (byte_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (byte_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL byte_timeout: got byte_ready %b expected 1", byte_ready);
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[i*8 +: 8]);
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, done}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int w0;
    logic [7:0] bp_bytes [8];
    logic [31:0] a, b;
    logic [7:0] k;

    rst_n = 1'b0; start = 1'b0; word_count = '0; abort = 1'b0;
    byte_valid = 1'b0; byte_data = '0;

    // 1: reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_wr_en",      {31'd0, wr_en},      32'd0);
    chk("rst_wr_addr",    wr_addr,             32'd0);
    chk("rst_wr_data",    wr_data,             32'd0);
    chk("rst_busy",       {31'd0, busy},       32'd0);
    chk("rst_done",       {31'd0, done},       32'd0);
    chk("rst_cpu_rst_n",  {31'd0, cpu_rst_n},  32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 2: single word, exact latency
    w0 = wr_cnt;
    do_start(9'd1);
    @(negedge clk);
    chk("t2_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    expect_wr(32'h0, 32'h20080005);
    send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
    @(negedge clk);
    chk("t2_wr_latency", {31'd0, wr_en}, 32'd1);
    @(negedge clk);
    chk("t2_done",      {31'd0, done},      32'd1);
    chk("t2_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
    chk("t2_wr_count",  wr_cnt - w0,        32'd1);
    @(posedge clk); #1;

    // 3: three words with gaps in byte_valid
    w0 = wr_cnt;
    do_start(9'd3);
    chk("t3_done_cleared", {31'd0, done}, 32'd0);
    expect_wr(32'h0, 32'h8C080010);
    expect_wr(32'h4, 32'h01094020);
    expect_wr(32'h8, 32'hAC0A0014);
    send_word(32'h8C080010, 2);
    send_word(32'h01094020, 0);
    send_word(32'hAC0A0014, 1);
    wait_done("t3_done");
    chk("t3_wr_count", wr_cnt - w0, 32'd3);

    // 4a: zero count
    reset_dut();
    w0 = wr_cnt;
    do_start(9'd0);
    @(negedge clk);
    chk("t4_zero_done", {31'd0, done}, 32'd1);
    chk("t4_zero_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("t4_zero_wr_count", wr_cnt - w0, 32'd0);

    // 4b: overflow count clamps to 256 words
    w0 = wr_cnt;
    do_start(9'd300);
    for (int i = 0; i < 256; i++) begin
      k = 8'(i);
      a = 32'(i) << 2;
      b = {k, ~k, 8'hA5, k ^ 8'h3C};
      expect_wr(a, b);
      send_word(b, 0);
    end
    wait_done("t4_ovf_done");
    chk("t4_ovf_wr_count", wr_cnt - w0, 32'd256);
    chk("t4_ovf_last_addr", last_addr, 32'h3FC);
    byte_valid = 1'b1; byte_data = 8'h55;
    @(negedge clk);
    chk("t4_done_no_ready", {31'd0, byte_ready}, 32'd0);
    @(posedge clk); #1 byte_valid = 1'b0;

    // 5: abort after 6 bytes of a 4-word load, then a fresh 1-word load
    w0 = wr_cnt;
    do_start(9'd4);
    expect_wr(32'h0, 32'h11223344);
    send_word(32'h11223344, 0);
    send_byte(8'h55); send_byte(8'h66);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("t5_abort_busy",      {31'd0, busy},      32'd0);
    chk("t5_abort_done",      {31'd0, done},      32'd0);
    chk("t5_abort_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    @(posedge clk); #1;
    chk("t5_abort_wr_count", wr_cnt - w0, 32'd1);
    w0 = wr_cnt;
    do_start(9'd1);
    expect_wr(32'h0, 32'hDEADBEEF);
    send_word(32'hDEADBEEF, 0);
    wait_done("t5_restart_done");
    chk("t5_restart_wr_count", wr_cnt - w0, 32'd1);

    // 6: back-pressure with byte_valid held high through WRITE
    w0 = wr_cnt;
    bp_bytes = '{8'h24, 8'h02, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h0C};
    do_start(9'd2);
    expect_wr(32'h0, 32'h2402000A);
    expect_wr(32'h4, 32'h0000000C);
    begin
      int idx, n;
      logic taken;
      idx = 0; n = 0;
      byte_valid = 1'b1;
      byte_data  = bp_bytes[0];
      while (idx < 8 && n < 100) begin
        @(negedge clk);
        if (wr_en === 1'b1) chk("t6_ready_in_write", {31'd0, byte_ready}, 32'd0);
        taken = byte_ready;
        @(posedge clk); #1;
        if (taken) begin
          idx++;
          if (idx < 8) byte_data = bp_bytes[idx];
        end
        n++;
      end
      byte_valid = 1'b0;
      chk("t6_all_bytes_taken", 32'(idx), 32'd8);
    end
    wait_done("t6_done");
    chk("t6_wr_count", wr_cnt - w0, 32'd2);

    // reset mid-word: no write may follow
    w0 = wr_cnt;
    do_start(9'd1);
    send_byte(8'hAA); send_byte(8'hBB);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rstmid_wr_count", wr_cnt - w0, 32'd0);
    chk("rstmid_busy",     {31'd0, busy}, 32'd0);
    chk("rstmid_done",     {31'd0, done}, 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
